// File: rtl/st_ta_pkg.sv
// Shared constants and width helpers for the streaming timing adapter.
package st_ta_pkg;

  localparam int MAX_RL = 3;

  function automatic int log2c(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic int fill_w(input int depth);
    return log2c(depth + 1);
  endfunction

endpackage

// File: rtl/st_ta_sync_fifo.sv
// Registered synchronous FIFO with a head register, so the output never falls through
// and holds the last popped beat while empty.
module st_ta_sync_fifo
  import st_ta_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push_i,
  input  logic                      pop_i,
  input  logic [DATA_WIDTH-1:0]     data_i,
  output logic [DATA_WIDTH-1:0]     data_o,
  output logic [fill_w(DEPTH)-1:0]  fill_level_o,
  output logic                      full_o,
  output logic                      empty_o
);

  localparam int AW = (log2c(DEPTH) < 1) ? 1 : log2c(DEPTH);
  localparam int FW = fill_w(DEPTH);
  localparam logic [FW-1:0] FULL_LVL = FW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wrPtr_q, wrPtr_d;
  logic [AW-1:0]         rdPtr_q, rdPtr_d;
  logic [FW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic                  wrEn, rdEn;

  assign full_o       = (count_q == FULL_LVL);
  assign empty_o      = (count_q == '0);
  assign rdEn         = pop_i & ~empty_o;
  assign wrEn         = push_i & (~full_o | rdEn);
  assign data_o       = head_q;
  assign fill_level_o = count_q;

  // The head register is preloaded with whatever entry sits at the next read pointer;
  // when that slot is being written this very cycle the incoming beat is forwarded.
  always_comb begin
    wrPtr_d = wrPtr_q + AW'(wrEn);
    rdPtr_d = rdPtr_q + AW'(rdEn);
    count_d = count_q + FW'(wrEn) - FW'(rdEn);
    head_d  = head_q;
    if (count_d != '0) begin
      if (wrEn && (wrPtr_q == rdPtr_d)) head_d = data_i;
      else                              head_d = mem_q[rdPtr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wrEn) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/st_timing_adapter_rl.sv
// Avalon-ST ready-latency adapter: IN_RL-latency source to OUT_RL-latency sink through a FIFO.
// Define ST_TA_OVF_CHK_EN to enable the sticky overflow flag for source protocol violations.
module st_timing_adapter_rl
  import st_ta_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 8,
  parameter int IN_RL      = 0,
  parameter int OUT_RL     = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      in_ready,
  input  logic                      in_valid,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [fill_w(DEPTH)-1:0]  fill_level,
  output logic                      overflow
);

  localparam int FW = fill_w(DEPTH);
  localparam logic [FW-1:0] READY_LVL = FW'(DEPTH - 1 - IN_RL);

  if ((DEPTH < IN_RL + 2) || ((DEPTH & (DEPTH - 1)) != 0) ||
      (IN_RL < 0) || (IN_RL > MAX_RL) || (OUT_RL < 0) || (OUT_RL > MAX_RL) ||
      (DATA_WIDTH < 1) || (DATA_WIDTH > 1024)) begin : g_cfgErr
    $error("st_timing_adapter_rl: illegal DATA_WIDTH/DEPTH/IN_RL/OUT_RL combination");
  end

  logic push, pop;
  logic fifoFull, fifoEmpty;

  // The threshold leaves one free slot per beat that may still be in flight from the source.
  assign in_ready = ~reset & (fill_level <= READY_LVL);

  if (IN_RL == 0) begin : g_inRl0
    assign push = in_valid & in_ready;
  end else begin : g_inRlN
    assign push = in_valid;
  end

  if (OUT_RL == 0) begin : g_outRl0
    assign out_valid = ~fifoEmpty;
    assign pop       = out_valid & out_ready;
  end else begin : g_outRlN
    logic [OUT_RL-1:0] rdyPipe_q, rdyPipe_d;

    assign rdyPipe_d = OUT_RL'({rdyPipe_q, out_ready});
    assign out_valid = rdyPipe_q[OUT_RL-1] & ~fifoEmpty;
    assign pop       = out_valid;

    always_ff @(posedge clk) begin
      if (reset) rdyPipe_q <= '0;
      else       rdyPipe_q <= rdyPipe_d;
    end
  end

  st_ta_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push),
    .pop_i        (pop),
    .data_i       (in_data),
    .data_o       (out_data),
    .fill_level_o (fill_level),
    .full_o       (fifoFull),
    .empty_o      (fifoEmpty)
  );

`ifdef ST_TA_OVF_CHK_EN
  logic ovf_q, ovf_d;
  logic ovfEvent;

  assign ovfEvent = push & fifoFull & ~pop;
  assign ovf_d    = ovf_q | ovfEvent;
  assign overflow = ovf_q;

  always_ff @(posedge clk) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && ovfEvent) $error("st_timing_adapter_rl: push while full, beat dropped");
  end
`endif
`else
  logic unusedFull;
  assign unusedFull = fifoFull;
  assign overflow   = 1'b0;
`endif

endmodule

// File: tb/tb_st_timing_adapter_rl.sv
// Randomised scoreboard bench for st_timing_adapter_rl (IN_RL=2, OUT_RL=1, DEPTH=8).
module tb_st_timing_adapter_rl;

  localparam int DW     = 16;
  localparam int DEPTH  = 8;
  localparam int IN_RL  = 2;
  localparam int OUT_RL = 1;
  localparam int FW     = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, in_valid, out_ready;
  logic          in_ready, out_valid, overflow;
  logic [DW-1:0] in_data, out_data;
  logic [FW-1:0] fill_level;

  int passCnt  = 0;
  int checkCnt = 0;

  // Reference model: stored beats in order, recent out_ready/in_ready history, overflow flag.
  logic [DW-1:0] expQ[$];
  logic [DW-1:0] expData;
  bit            rdyHist[$];
  bit            irHist[$];
  bit            ovfExp;
  logic [DW-1:0] nextData;

  st_timing_adapter_rl #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .IN_RL      (IN_RL),
    .OUT_RL     (OUT_RL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_ready   (in_ready),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .fill_level (fill_level),
    .overflow   (overflow)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCnt++;
    if (act === exp) passCnt++;
    else $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
  endtask

  // Drive one clock of inputs and advance the model at the edge that consumes them.
  task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic r, input logic rst);
    bit attempted;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    reset     = rst;
    @(posedge clk);
    if (rst) begin
      expQ.delete();
      expData = '0;
      ovfExp  = 1'b0;
      rdyHist.delete();
      for (int i = 0; i < OUT_RL; i++) rdyHist.push_back(1'b0);
    end else begin
      attempted = v && (IN_RL != 0 || irHist[irHist.size() - 1]);
      if (attempted) begin
        if (expQ.size() < DEPTH) expQ.push_back(d);
        else                     ovfExp = 1'b1;
      end
      if (OUT_RL > 0) begin
        rdyHist.push_back(r);
        void'(rdyHist.pop_front());
      end
    end
    #1;
    irHist.push_back(in_ready);
    if (irHist.size() > IN_RL + 1) void'(irHist.pop_front());
  endtask

  function automatic bit canPush();
    return irHist[irHist.size() - 1 - IN_RL];
  endfunction

  task automatic streamCycle(input bit want, input logic r);
    bit v;
    v = want && canPush();
    applyStimulus(v, nextData, r, 1'b0);
    if (v) nextData++;
  endtask

  task automatic fillBeats(input int n, input logic r);
    int got;
    int budget;
    bit v;
    got    = 0;
    budget = 60;
    while (got < n && budget > 0) begin
      v = canPush();
      applyStimulus(v, nextData, r, 1'b0);
      if (v) begin
        nextData++;
        got++;
      end
      budget--;
    end
    if (got < n) begin
      checkCnt++;
      $display("[TB] FAIL fill_timeout: pushed=%0d required=%0d", got, n);
    end
  endtask

  // Monitor: compares every cycle on the falling edge and retires beats the sink takes.
  initial begin : monitor
    int   sz;
    logic expValid;
    logic ovfRequired;
    @(posedge clk);
    forever begin
      @(negedge clk);
      sz = expQ.size();
      if (sz > 0) expData = expQ[0];
      expValid = (sz > 0) && (OUT_RL == 0 || rdyHist[0]);
`ifdef ST_TA_OVF_CHK_EN
      ovfRequired = ovfExp;
`else
      ovfRequired = 1'b0;
`endif
      checkOutput("out_valid", 64'(out_valid), 64'(expValid));
      checkOutput("out_data", 64'(out_data), 64'(expData));
      checkOutput("fill_level", 64'(fill_level), 64'(sz));
      checkOutput("in_ready", 64'(in_ready), 64'(!reset && sz <= DEPTH - 1 - IN_RL));
      checkOutput("overflow", 64'(overflow), 64'(ovfRequired));
      if (expValid && (OUT_RL != 0 || out_ready)) void'(expQ.pop_front());
    end
  end

  initial begin : stimulus
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    reset     = 1'b1;
    nextData  = 16'h0001;
    expData   = '0;
    ovfExp    = 1'b0;
    for (int i = 0; i < OUT_RL; i++) rdyHist.push_back(1'b0);
    for (int i = 0; i <= IN_RL; i++) irHist.push_back(1'b0);

    repeat (3) applyStimulus(1'b0, '0, 1'b0, 1'b1);

    $display("[TB] fill to full with sink stalled, then drain");
    repeat (16) streamCycle(1'b1, 1'b0);
    repeat (12) streamCycle(1'b0, 1'b1);

    $display("[TB] five beats against out_ready pattern 1,0,1,1,0");
    fillBeats(5, 1'b0);
    streamCycle(1'b0, 1'b1);
    streamCycle(1'b0, 1'b0);
    streamCycle(1'b0, 1'b1);
    streamCycle(1'b0, 1'b1);
    streamCycle(1'b0, 1'b0);
    repeat (3) streamCycle(1'b0, 1'b0);
    repeat (8) streamCycle(1'b0, 1'b1);

    $display("[TB] push 0xAA into a full FIFO during a pop, then push 0xBB with no pop");
    fillBeats(8, 1'b0);
    repeat (3) streamCycle(1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h00AA, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h00BB, 1'b0, 1'b0);
    repeat (2) streamCycle(1'b0, 1'b0);
    repeat (12) streamCycle(1'b0, 1'b1);

    $display("[TB] reset with beats stored, then first beat 0x55");
    fillBeats(5, 1'b0);
    repeat (2) applyStimulus(1'b0, '0, 1'b1, 1'b1);
    nextData = 16'h0055;
    fillBeats(1, 1'b1);
    repeat (4) streamCycle(1'b0, 1'b1);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      nextData = DW'($urandom);
      streamCycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
    end
    repeat (20) streamCycle(1'b0, 1'b1);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
